// File: rtl/counter_pkg.sv
// Shared defaults and helpers for the modulo-N counter.
package counter_pkg;

  localparam int COUNTER_WIDTH_DEF = 4;
  localparam int COUNTER_MAX_DEF   = 15;
  localparam int WRAP_CNT_W_DEF    = 8;

  // Binary to reflected Gray code; callers truncate to their own width.
  function automatic logic [63:0] bin2gray(input logic [63:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/counter_wrap_tracker.sv
// Wrap status for the counter: one-cycle wrap pulse and a saturating wrap count.
module counter_wrap_tracker
  import counter_pkg::*;
#(
  parameter int WRAP_CNT_W = WRAP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tc,
  output logic                  wrap,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
);

  localparam logic [WRAP_CNT_W-1:0] CNT_ONE = WRAP_CNT_W'(1);

  logic                  wrap_d;
  logic                  wrap_q;
  logic [WRAP_CNT_W-1:0] wrap_cnt_d;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q;

  always_comb begin
    wrap_d     = tc & ~rst;
    wrap_cnt_d = wrap_cnt_q;
    if (rst) begin
      wrap_cnt_d = '0;
    end else if (tc && !(&wrap_cnt_q)) begin
      wrap_cnt_d = wrap_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: rtl/counter.sv
// Free-running modulo-(MAX_VALUE+1) up-counter with terminal-count and wrap status.
// Define COUNTER_GRAY_OUT_EN to add the count_gray output.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH      = COUNTER_WIDTH_DEF,
  parameter int MAX_VALUE  = COUNTER_MAX_DEF,
  parameter int WRAP_CNT_W = WRAP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  wrap,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
`ifdef COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0]      count_gray
`endif
);

  localparam longint MAX_LEGAL = (longint'(1) << WIDTH) - 1;

  generate
    if (MAX_VALUE < 1 || longint'(MAX_VALUE) > MAX_LEGAL) begin : g_bad_max
      $error("counter: MAX_VALUE %0d outside 1..%0d", MAX_VALUE, MAX_LEGAL);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;
  logic             tc_int;

  assign tc_int = (count_q == MAX_C);

  always_comb begin
    count_d = count_q + ONE;
    if (rst || tc_int) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  counter_wrap_tracker #(
    .WRAP_CNT_W (WRAP_CNT_W)
  ) u_wrap_tracker (
    .clk      (clk),
    .rst      (rst),
    .tc       (tc_int),
    .wrap     (wrap),
    .wrap_cnt (wrap_cnt)
  );

  assign count = count_q;
  assign tc    = tc_int;

`ifdef COUNTER_GRAY_OUT_EN
  // Decoded from the register so it carries the same timing as count.
  assign count_gray = WIDTH'(bin2gray(64'(count_q)));
`endif

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: defaults, MAX_VALUE=9 and WRAP_CNT_W=2 instances share clk/rst.
`timescale 1ns/1ps
module tb_counter;

  logic       clk;
  logic       rst;

  logic [3:0] count_a,  count_b,  count_c;
  logic       tc_a,     tc_b,     tc_c;
  logic       wrap_a,   wrap_b,   wrap_c;
  logic [7:0] wcnt_a,   wcnt_b;
  logic [1:0] wcnt_c;
`ifdef COUNTER_GRAY_OUT_EN
  logic [3:0] gray_a, gray_b, gray_c;
`endif

  int n_checks = 0;
  int n_errors = 0;

  counter dut_a (
    .clk(clk), .rst(rst), .count(count_a), .tc(tc_a), .wrap(wrap_a), .wrap_cnt(wcnt_a)
`ifdef COUNTER_GRAY_OUT_EN
    , .count_gray(gray_a)
`endif
  );

  counter #(.MAX_VALUE(9)) dut_b (
    .clk(clk), .rst(rst), .count(count_b), .tc(tc_b), .wrap(wrap_b), .wrap_cnt(wcnt_b)
`ifdef COUNTER_GRAY_OUT_EN
    , .count_gray(gray_b)
`endif
  );

  counter #(.WRAP_CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .count(count_c), .tc(tc_c), .wrap(wrap_c), .wrap_cnt(wcnt_c)
`ifdef COUNTER_GRAY_OUT_EN
    , .count_gray(gray_c)
`endif
  );

  // 14 ns period, first rising edge at 7 ns
  initial clk = 1'b0;
  always #7 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs n edges after reset release, for all three instances.
  task automatic check_all(input int n);
    int sat;
    check("a_count", 32'(count_a), 32'(n % 16));
    check("a_tc",    32'(tc_a),    32'((n % 16) == 15));
    check("a_wrap",  32'(wrap_a),  32'((n > 0) && (n % 16) == 0));
    check("a_wcnt",  32'(wcnt_a),  32'(n / 16));
    check("b_count", 32'(count_b), 32'(n % 10));
    check("b_tc",    32'(tc_b),    32'((n % 10) == 9));
    check("b_wrap",  32'(wrap_b),  32'((n > 0) && (n % 10) == 0));
    check("b_wcnt",  32'(wcnt_b),  32'(n / 10));
    sat = (n / 16 > 3) ? 3 : n / 16;
    check("c_count", 32'(count_c), 32'(n % 16));
    check("c_wcnt",  32'(wcnt_c),  32'(sat));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count_a), 32'd0);
    check({tag, "_tc"},    32'(tc_a),    32'd0);
    check({tag, "_wrap"},  32'(wrap_a),  32'd0);
    check({tag, "_wcnt"},  32'(wcnt_a),  32'd0);
    check({tag, "_bcnt"},  32'(count_b), 32'd0);
    check({tag, "_cwcnt"}, 32'(wcnt_c),  32'd0);
  endtask

`ifdef COUNTER_GRAY_OUT_EN
  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
`endif

  initial begin
`ifdef COUNTER_GRAY_OUT_EN
    logic [3:0] gray_prev;
`endif
    rst = 1'b1;
    #10 rst = 1'b0;

    // Reset edge at 7 ns, then counting through a wrap of both moduli.
    @(negedge clk);
    check_reset_state("rst0");
    for (int i = 0; i <= 38; i++) begin
      if (i > 0) @(negedge clk);
      check_all(i);
    end

    // Reset for one cycle while count_a = 6.
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst6");
    rst = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      check_all(j);
    end

    // Reset while count_a = 15: no wrap recorded; hold reset for two edges.
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst15");
    @(negedge clk);
    check_reset_state("hold");
    rst = 1'b0;

    // Long run: saturation of the 2-bit wrap counter and Gray output.
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      check_all(j);
`ifdef COUNTER_GRAY_OUT_EN
      check("a_gray", 32'(gray_a), 32'(gray_tab[j % 16]));
      if (j > 1) check("a_gray_step", 32'($countones(gray_a ^ gray_prev)), 32'd1);
      gray_prev = gray_a;
`endif
    end
    check("c_wcnt_sat", 32'(wcnt_c), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
